// File: rtl/wb_j1_data_cache.sv
// wb_j1_data_cache: direct-mapped write-through data cache between the J1 core and Wishbone
module wb_j1_data_cache #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cache_data_valid,
    input  logic              cache_data_rd_wr,
    input  logic [ADDR_W-1:0] cache_data_addr,
    input  logic [DATA_W-1:0] cache_data_din,
    input  logic              cache_data_hold,
    output logic              cache_data_miss,
    output logic              cache_data_wr_wait,
    output logic [DATA_W-1:0] cache_data_dout,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W+1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i
);
    localparam int LINES = 2 ** IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

    state_t              state, state_nx;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [LINES];
    logic                wb_full;
    logic [ADDR_W-1:0]   wb_addr, fill_addr, adr_nx;
    logic [DATA_W-1:0]   wb_data, dat_nx;

    logic [IDX_W-1:0] idx, fill_idx;
    logic [TAG_W-1:0] tag_in, fill_tag;
    logic hit, wr_accept, rd_miss, write_done, fill_done;

    assign idx        = cache_data_addr[IDX_W-1:0];
    assign tag_in     = cache_data_addr[ADDR_W-1:IDX_W];
    assign fill_idx   = fill_addr[IDX_W-1:0];
    assign fill_tag   = fill_addr[ADDR_W-1:IDX_W];
    assign hit        = valid_q[idx] && (tag_q[idx] == tag_in);
    assign wr_accept  = cache_data_valid && cache_data_rd_wr && !wb_full && !cache_data_hold;
    assign rd_miss    = cache_data_valid && !cache_data_rd_wr && !hit;
    assign write_done = (state == WRITE) && wb_ack_i;
    assign fill_done  = (state == FILL) && wb_ack_i;

    // Read hits are served even while the write buffer drains; only a fill blocks them.
    assign cache_data_miss    = cache_data_valid && !cache_data_rd_wr && (!hit || state == FILL);
    assign cache_data_wr_wait = cache_data_valid && cache_data_rd_wr && wb_full;
    assign cache_data_dout    = data_q[idx];
    assign wb_stb_o           = wb_cyc_o;
    assign wb_sel_o           = 4'hf;

    // Next state with write-buffer priority; bus address/data for the next cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = (wb_full || wr_accept) ? WRITE : rd_miss ? FILL : IDLE;
            WRITE:   state_nx = !wb_ack_i ? WRITE : rd_miss ? FILL : IDLE;
            FILL:    state_nx = wb_ack_i ? IDLE : FILL;
            default: state_nx = IDLE;
        endcase
        adr_nx = (state_nx == WRITE) ? (wb_full ? wb_addr : cache_data_addr) :
                 (state_nx == FILL)  ? ((state == FILL) ? fill_addr : cache_data_addr) : '0;
        dat_nx = (state_nx == WRITE) ? (wb_full ? wb_data : cache_data_din) : '0;
    end

    // Control state, write buffer, valid bits and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wb_full   <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            fill_addr <= '0;
            valid_q   <= '0;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
        end else begin
            state    <= state_nx;
            wb_full  <= wr_accept ? 1'b1 : write_done ? 1'b0 : wb_full;
            wb_cyc_o <= state_nx != IDLE;
            wb_we_o  <= state_nx == WRITE;
            wb_adr_o <= {adr_nx, 2'b00};
            wb_dat_o <= dat_nx;
            if (wr_accept) begin
                wb_addr <= cache_data_addr;
                wb_data <= cache_data_din;
            end
            if (state != FILL && state_nx == FILL) fill_addr <= cache_data_addr;
            if (fill_done) valid_q[fill_idx] <= 1'b1;
        end
    end

    // Line storage: store hits update in place, fills replace tag and data.
    always_ff @(posedge clk) begin
        if (wr_accept && hit) data_q[idx] <= cache_data_din;
        if (fill_done) begin
            data_q[fill_idx] <= wb_dat_i;
            tag_q[fill_idx]  <= fill_tag;
        end
    end
endmodule

// File: tb/tb_wb_j1_data_cache.sv
// tb_wb_j1_data_cache: directed bench with a Wishbone slave that scores bus cycles against a queue
module tb_wb_j1_data_cache;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid, rd_wr, hold, miss, wr_wait;
    logic [15:0] addr;
    logic [31:0] din, dout;
    logic        cyc, stb, we;
    logic [17:0] adr;
    logic [31:0] dat_o;
    logic [3:0]  sel;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;

    typedef struct {
        logic        we;
        logic [17:0] adr;
        logic [31:0] dat;
    } txn_t;

    txn_t sb[$];
    txn_t slv_t;
    int checks = 0, errors = 0, lat = 2, acks = 0, cnt = 0;

    wb_j1_data_cache dut (
        .clk(clk), .rst_n(rst_n),
        .cache_data_valid(valid), .cache_data_rd_wr(rd_wr), .cache_data_addr(addr),
        .cache_data_din(din), .cache_data_hold(hold), .cache_data_miss(miss),
        .cache_data_wr_wait(wr_wait), .cache_data_dout(dout),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_dat_o(dat_o),
        .wb_sel_o(sel), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic w, input logic [17:0] a, input logic [31:0] d);
        txn_t t;
        t.we = w;
        t.adr = a;
        t.dat = d;
        sb.push_back(t);
    endtask

    // Slave: acks after lat waiting cycles, checks each bus cycle against the scoreboard.
    always @(negedge clk) begin
        wb_ack_i = 1'b0;
        if (!cyc) cnt = 0;
        else if (cnt < lat) cnt++;
        else begin
            cnt = 0;
            wb_ack_i = 1'b1;
            acks++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL bus_unexpected observed adr %0h expected no cycle", adr);
            end
            if (sb.size() != 0) begin
                slv_t = sb.pop_front();
                chk("bus_we", we, slv_t.we);
                chk("bus_adr", adr, slv_t.adr);
                if (slv_t.we) chk("bus_dat", dat_o, slv_t.dat);
                else wb_dat_i = slv_t.dat;
            end
        end
    end

    task automatic rd(input logic [15:0] a, input logic [31:0] exp, input int ew);
        int n = 0;
        @(posedge clk); #1;
        valid = 1'b1; rd_wr = 1'b0; addr = a; hold = 1'b0;
        @(negedge clk); #1;
        while (miss && n < 60) begin
            n++;
            @(posedge clk); #1;
            @(negedge clk); #1;
        end
        chk("rd_wait", n, ew);
        chk("rd_dout", dout, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input int ew);
        int n = 0;
        @(posedge clk); #1;
        valid = 1'b1; rd_wr = 1'b1; addr = a; din = d; hold = 1'b0;
        @(negedge clk); #1;
        while (wr_wait && n < 60) begin
            n++;
            @(posedge clk); #1;
            @(negedge clk); #1;
        end
        chk("wr_wait", n, ew);
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk); #1;
        while ((sb.size() != 0 || cyc) && n < 100) begin
            n++;
            @(negedge clk); #1;
        end
        chk("drain", {sb.size() != 0, cyc}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a0;
        valid = 1'b0; rd_wr = 1'b0; addr = '0; din = '0; hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_bus", {cyc, stb, we}, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_sel", sel, 4'hf);
        chk("rst_idle", {miss, wr_wait}, 0);
        valid = 1'b1; #1;
        chk("rst_rd_miss", miss, 1);
        rd_wr = 1'b1; #1;
        chk("rst_wr_wait", wr_wait, 0);
        valid = 1'b0; rd_wr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        lat = 2;
        push(1'b0, 18'h14, 32'hDEADBEEF);
        rd(16'h0005, 32'hDEADBEEF, 4);
        rd(16'h0005, 32'hDEADBEEF, 0);

        push(1'b1, 18'h14, 32'h12345678);
        wr(16'h0005, 32'h12345678, 0);
        rd(16'h0005, 32'h12345678, 0);
        chk("drain_bus", {cyc, stb, we}, 3'b111);
        drain();

        lat = 1;
        push(1'b1, 18'h40, 32'hA0A0A0A0);
        push(1'b1, 18'h44, 32'hB1B1B1B1);
        wr(16'h0010, 32'hA0A0A0A0, 0);
        wr(16'h0011, 32'hB1B1B1B1, 2);
        drain();

        lat = 2;
        push(1'b1, 18'h114, 32'hC0FFEE00);
        push(1'b0, 18'h114, 32'h0D0D0D0D);
        wr(16'h0045, 32'hC0FFEE00, 0);
        rd(16'h0045, 32'h0D0D0D0D, 6);
        push(1'b0, 18'h14, 32'hEEEE1111);
        rd(16'h0005, 32'hEEEE1111, 4);

        lat = 10;
        @(posedge clk); #1;
        valid = 1'b1; rd_wr = 1'b0; addr = 16'h0020;
        @(negedge clk); #1;
        chk("fill_miss", miss, 1);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("fill_cyc", cyc, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        chk("async_bus", {cyc, stb, we}, 0);
        chk("async_adr", adr, 0);
        @(negedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        lat = 2;
        push(1'b0, 18'h14, 32'hF00DF00D);
        rd(16'h0005, 32'hF00DF00D, 4);

        a0 = acks;
        @(posedge clk); #1;
        valid = 1'b1; rd_wr = 1'b1; addr = 16'h0007; din = 32'h600D600D; hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("hold_wr_wait", wr_wait, 0);
            chk("hold_cyc", cyc, 0);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        hold = 1'b0;
        push(1'b1, 18'h1C, 32'h600D600D);
        @(negedge clk); #1;
        chk("hold_release", wr_wait, 0);
        drain();
        chk("hold_one_write", acks - a0, 1);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_j1_data_cache.md
# wb_j1_data_cache

Direct-mapped, write-through, no-write-allocate data cache sitting directly downstream of the J1 core's `cache_data_*` port and upstream of the Wishbone bus. Serves read hits combinationally in the same cycle, stalls the core through `cache_data_miss` on read misses, and absorbs stores into a one-entry write buffer. The cache asserts `cache_data_wr_wait` only while that buffer is still draining to Wishbone.

## Interface
- `ADDR_W`, 16: word-address width of `cache_data_addr`.
- `DATA_W`, 32: data word width.
- `IDX_W`, 6: index bits; `2**IDX_W` one-word lines.
- `clk  in  1`: single clock; all state on rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `cache_data_valid  in  1`: core access request, combinational from core, held while core stalled.
- `cache_data_rd_wr  in  1`: 1 = write, 0 = read.
- `cache_data_addr  in  ADDR_W`: word address.
- `cache_data_din  in  DATA_W`: store data.
- `cache_data_hold  in  1`: core stalled for another reason (instruction miss); blocks write acceptance.
- `cache_data_miss  out  1`: read not yet serviceable; core must stall.
- `cache_data_wr_wait  out  1`: write not accepted this cycle; core must stall.
- `cache_data_dout  out  DATA_W`: read data, valid when read and `!cache_data_miss`.
- `wb_cyc_o, wb_stb_o  out  1`: Wishbone classic cycle/strobe, always driven together.
- `wb_we_o  out  1`: Wishbone write enable.
- `wb_adr_o  out  ADDR_W+2`: byte address `{word_addr, 2'b00}`.
- `wb_dat_o  out  DATA_W`: write data.
- `wb_sel_o  out  4`: constant `4'hf`.
- `wb_dat_i  in  DATA_W`: read data.
- `wb_ack_i  in  1`: cycle termination. No err/rty support.

## Operation
- Address split: `index = addr[IDX_W-1:0]`; `tag = addr[ADDR_W-1:IDX_W]`. Arrays are `valid[]`, `tag[]`, and `data[]`, read asynchronously. `hit = valid[index] && tag[index]==tag`.
- States: IDLE, WRITE (draining buffer), FILL (read miss).
- Write buffer: `wb_full`, `wb_addr`, `wb_data`.
- Write acceptance:
  - Condition: `valid & rd_wr & !wb_full & !hold`.
  - At the edge: `wb_addr`/`wb_data` are loaded and `wb_full` is set.
  - On a hit, `data[index]` is updated at the same edge.
  - On a miss, no allocation.
- `cache_data_wr_wait = valid & rd_wr & wb_full`. It is combinational, and it ignores an ack arriving in the same cycle.
- `cache_data_miss = valid & !rd_wr & (!hit | state!=IDLE | wb_full)`.
  - Exception: a read hit with `wb_full` and state IDLE or WRITE is not a miss. Effectively `miss = valid & !rd_wr & (!hit | state==FILL)`.
- `cache_data_dout = data[index]` unconditionally. It is don't-care when not a read hit.
- Transitions out of IDLE, with write-buffer priority:
  - `wb_full` → WRITE.
  - Otherwise, read miss → FILL, latching `fill_addr`.
- WRITE: `cyc=stb=we=1`, `adr={wb_addr,2'b00}`, `dat_o=wb_data`.
  - On `wb_ack_i`: clear `wb_full`.
  - Then → FILL if a read miss is presented, else → IDLE.
  - A new write cannot enter the buffer in the ack cycle.
- FILL: `cyc=stb=1`, `we=0`, `adr={fill_addr,2'b00}`.
  - On `wb_ack_i`: `data[fill_index]<=wb_dat_i`, `tag<=fill_tag`, `valid<=1`, → IDLE.
- `cyc/stb/we` are registered from next-state. They are never asserted in IDLE.
- Reset mid-operation:
  - All `valid[]` are cleared, `wb_full=0`, state IDLE, bus outputs 0, immediately (async).
  - A late `wb_ack_i` after reset is ignored.
- Reset values: `cache_data_miss` and `cache_data_wr_wait` follow their equations with state IDLE and `wb_full=0`. `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `wb_adr_o`, and `wb_dat_o` are 0. `wb_sel_o` is `4'hf`.

## Timing
- Read hit: 0 wait cycles; `dout` valid in the request cycle.
- Read miss, buffer empty:
  - Cycle 0: `miss=1`.
  - Cycle 1: `cyc/stb` high.
  - Ack in cycle N: line written at the end of N.
  - Cycle N+1: hit, `miss=0`.
- Write with buffer empty: accepted in cycle 0 (`wr_wait=0`); bus write begins cycle 1.
- Back-to-back writes: the second sees `wr_wait=1` until the cycle after the first ack. Minimum store spacing is ack latency + 2 cycles.
- Read miss during a pending write: the write completes first; FILL starts the cycle after the write ack.
- A `hold` asserted with a write presented keeps it unaccepted. `wr_wait` still reflects only `wb_full`.

## Test plan
- Reset, then read `0x0005`; slave acks after 2 cycles with `0xDEADBEEF`.
  - `miss=1` for 4 cycles, `wb_adr_o=0x0014`.
  - Next cycle: `dout=0xDEADBEEF`, `miss=0`.
  - A re-read of `0x0005` is a 0-wait hit.
- Write `0x12345678` to cached `0x0005`.
  - Accepted with `wr_wait=0`.
  - Bus write to `0x0014`.
  - An immediate read of `0x0005` hits with `0x12345678` while the write drains.
- Two consecutive writes, with ack latency 1: the second write sees `wr_wait=1` for exactly 2 cycles; both bus writes appear in order.
- Write to uncached `0x0045`, then read `0x0045`.
  - The bus write completes before the fill read.
  - The fill returns the slave's value and allocates index 5, evicting `0x0005`.
  - A read of `0x0005` now misses.
- Assert `rst_n=0` during FILL with `cyc=1`: bus outputs drop the same cycle, and after release the prior line misses.
- Write with `hold=1` for 3 cycles: no buffer load or bus activity until `hold` drops; then exactly one bus write.
